// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// shift_pkg : shared op and state encodings for the shift sequencer
// Rev 1.0
// ============================================================================
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage
`default_nettype wire

// File: rtl/shift1_unit.sv
`default_nettype none
// ============================================================================
// shift1_unit : combinational single-bit shifter (SLL/SRL/SRA/ROR by one)
// Rev 1.0
// ============================================================================
module shift1_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = A;
    case (shift_op_e'(op))
      SH_SLL:  res = {A[WIDTH-2:0], 1'b0};
      SH_SRL:  res = {1'b0, A[WIDTH-1:1]};
      SH_SRA:  res = {A[WIDTH-1], A[WIDTH-1:1]};
      SH_ROR:  res = {A[0], A[WIDTH-1:1]};
      default: res = A;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
// shift_seq : multi-cycle shift sequencer stepping a 1-bit shifter per clock
// Rev 1.0
// ============================================================================
module shift_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  state_e           r_state;
  shift_op_e        r_op;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_step;

  shift1_unit #(
    .WIDTH (WIDTH)
  ) u_shift1 (
    .A   (r_acc),
    .op  (r_op),
    .res (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= SH_SLL;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        // DONE accepts a new request exactly like IDLE, enabling back-to-back ops
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_acc   <= din;
            r_cnt   <= shamt;
            r_op    <= shift_op_e'(op);
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (r_cnt != '0) begin
            r_acc <= w_step;
            r_cnt <= r_cnt - SHW'(1);
          end else begin
            r_dout  <= r_acc;
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
// tb_shift_seq : scoreboard-driven bench for shift_seq
// Rev 1.0
// ============================================================================
module tb_shift_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] din   = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] dout;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  shift_seq #(
    .WIDTH (32),
    .SHW   (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .shamt (shamt),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [4:0] s,
                                            input logic [31:0] d);
    logic [63:0] dd;
    dd = {d, d} >> s;
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 32'($signed(d) >>> s);
      default: return dd[31:0];
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d,
                        input bit pulse, output int lat, output int bcnt, output bit both,
                        output bit tmo, output logic [1:0] db1, output logic [31:0] mid);
    op = o; shamt = s; din = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); din = $urandom; shamt = 5'($urandom);
    lat = 1; bcnt = 0; tmo = 1'b0; db1 = {done, busy}; mid = dout;
    while (!done) begin
      if (lat >= 40) begin tmo = 1'b1; break; end
      if (busy) bcnt++;
      if (lat == 2) mid = dout;
      start = pulse && (lat % 2 == 0);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    both = done && busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (dout !== 32'd0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_srl_ignore();
    int lat, bcnt; bit both, tmo; logic [1:0] db1; logic [31:0] mid, exp;
    exp_q.push_back(ref_shift(2'b01, 5'd4, 32'h8000_0000));
    run_op(2'b01, 5'd4, 32'h8000_0000, 1'b1, lat, bcnt, both, tmo, db1, mid);
    exp = exp_q.pop_front();
    checks++; if (tmo) begin failures++; $display("FAIL srl_timeout got=no_done exp=done"); end
    checks++; if (dout !== exp) begin failures++; $display("FAIL srl_dout got=%h exp=%h", dout, exp); end
    checks++; if (lat - 1 != 5) begin failures++; $display("FAIL srl_latency got=%0d exp=5", lat - 1); end
    checks++; if (bcnt != 5) begin failures++; $display("FAIL srl_busy_cycles got=%0d exp=5", bcnt); end
    checks++; if (both) begin failures++; $display("FAIL srl_done_busy_overlap got=1 exp=0"); end
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b00) begin failures++; $display("FAIL srl_back_idle got=%b exp=00", {done, busy}); end
  endtask

  task automatic test_sra_max();
    int lat, bcnt; bit both, tmo; logic [1:0] db1; logic [31:0] mid, exp;
    exp_q.push_back(ref_shift(2'b10, 5'd31, 32'hF000_0000));
    run_op(2'b10, 5'd31, 32'hF000_0000, 1'b0, lat, bcnt, both, tmo, db1, mid);
    exp = exp_q.pop_front();
    checks++; if (tmo) begin failures++; $display("FAIL sra_timeout got=no_done exp=done"); end
    checks++; if (dout !== exp) begin failures++; $display("FAIL sra_dout got=%h exp=%h", dout, exp); end
    checks++; if (lat - 1 != 32) begin failures++; $display("FAIL sra_latency got=%0d exp=32", lat - 1); end
    @(negedge clk);
  endtask

  task automatic test_ror();
    int lat, bcnt; bit both, tmo; logic [1:0] db1; logic [31:0] mid, exp;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] d; logic [4:0] s;
      d = (k == 0) ? 32'h0000_0001 : $urandom;
      s = (k == 0) ? 5'd1 : 5'($urandom_range(2, 30));
      exp_q.push_back(ref_shift(2'b11, s, d));
      run_op(2'b11, s, d, 1'b0, lat, bcnt, both, tmo, db1, mid);
      exp = exp_q.pop_front();
      checks++; if (tmo || dout !== exp) begin failures++; $display("FAIL ror_dout[%0d] got=%h exp=%h", k, dout, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_sll_zero();
    int lat, bcnt; bit both, tmo; logic [1:0] db1; logic [31:0] mid, exp;
    exp_q.push_back(ref_shift(2'b00, 5'd0, 32'h1234_5678));
    run_op(2'b00, 5'd0, 32'h1234_5678, 1'b0, lat, bcnt, both, tmo, db1, mid);
    exp = exp_q.pop_front();
    checks++; if (tmo || dout !== exp) begin failures++; $display("FAIL sll0_dout got=%h exp=%h", dout, exp); end
    checks++; if (lat - 1 != 1) begin failures++; $display("FAIL sll0_latency got=%0d exp=1", lat - 1); end
    checks++; if (bcnt != 1) begin failures++; $display("FAIL sll0_busy_cycles got=%0d exp=1", bcnt); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; bit both, tmo; logic [1:0] db1; logic [31:0] mid, exp1, exp2;
    exp_q.push_back(ref_shift(2'b00, 5'd3, 32'h0000_000A));
    run_op(2'b00, 5'd3, 32'h0000_000A, 1'b0, lat, bcnt, both, tmo, db1, mid);
    exp1 = exp_q.pop_front();
    checks++; if (tmo || dout !== exp1) begin failures++; $display("FAIL b2b_first_dout got=%h exp=%h", dout, exp1); end
    exp_q.push_back(ref_shift(2'b00, 5'd31, 32'h0000_0001));
    run_op(2'b00, 5'd31, 32'h0000_0001, 1'b0, lat, bcnt, both, tmo, db1, mid);
    exp2 = exp_q.pop_front();
    checks++; if (db1 !== 2'b01) begin failures++; $display("FAIL b2b_restart_done_busy got=%b exp=01", db1); end
    checks++; if (mid !== exp1) begin failures++; $display("FAIL b2b_dout_hold got=%h exp=%h", mid, exp1); end
    checks++; if (tmo || dout !== exp2) begin failures++; $display("FAIL b2b_second_dout got=%h exp=%h", dout, exp2); end
    checks++; if (lat - 1 != 32) begin failures++; $display("FAIL b2b_latency got=%0d exp=32", lat - 1); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int lat, bcnt, ndone; bit both, tmo; logic [1:0] db1; logic [31:0] mid, exp;
    exp_q.push_back(ref_shift(2'b00, 5'd20, 32'h0000_0003));
    op = 2'b00; shamt = 5'd20; din = 32'h0000_0003; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (dout !== 32'd0) begin failures++; $display("FAIL rstmid_dout got=%h exp=0", dout); end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    checks++; if (ndone != 0) begin failures++; $display("FAIL rstmid_stays_idle got=%0d exp=0", ndone); end
    exp_q.push_back(ref_shift(2'b11, 5'd5, 32'hDEAD_BEEF));
    run_op(2'b11, 5'd5, 32'hDEAD_BEEF, 1'b0, lat, bcnt, both, tmo, db1, mid);
    exp = exp_q.pop_front();
    checks++; if (tmo || dout !== exp) begin failures++; $display("FAIL rstmid_fresh_dout got=%h exp=%h", dout, exp); end
    checks++; if (lat - 1 != 6) begin failures++; $display("FAIL rstmid_fresh_latency got=%0d exp=6", lat - 1); end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_srl_ignore();
    test_sra_max();
    test_ror();
    test_sll_zero();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift sequencer for the datapath's shift path. It accepts one shift request with operand, operation and shift amount. It then steps a single-bit shift unit once per clock until the amount is exhausted, and returns the result with a one-cycle `done` pulse. It sits between the control unit and the ALU result mux, so SLL/SRL/SRA/ROR by 0..31 need only a 1-bit shifter in hardware.

## Interface
- `WIDTH`, 32, operand/result width in bits.
- `SHW`, 5, shift-amount width; WIDTH must equal 2**SHW.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe, sampled on rising edge.
- `op`  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
- `shamt`  in  SHW  shift amount, 0..WIDTH-1.
- `din`  in  WIDTH  operand.
- `busy`  out  1  high while shifting (state SHIFT).
- `done`  out  1  one-cycle pulse; `dout` valid from this cycle.
- `dout`  out  WIDTH  last completed result; holds until the next completion.

## Operation
- States:
  - IDLE: wait.
  - SHIFT: step.
  - DONE: one cycle, publish.
- Request accepted when `start`=1 and state is IDLE or DONE (back-to-back allowed). `start` in SHIFT is ignored, with no queuing.
- Accept edge: latch `din`→acc, `shamt`→cnt, `op`→op_r; state→SHIFT. `din`, `op` and `shamt` need only be valid on that edge.
- SHIFT:
  - If cnt≠0: acc←step(acc, op_r), cnt←cnt-1, stay in SHIFT.
  - If cnt=0: dout←acc, state→DONE.
- Step per op:
  - SLL: acc<<1, zero fill.
  - SRL: acc>>1, zero fill.
  - SRA: acc>>1, fill with acc[WIDTH-1].
  - ROR: {acc[0], acc[WIDTH-1:1]}.
- DONE: `done`=1. Next state is SHIFT if `start`=1, else IDLE.
- shamt=0: one SHIFT cycle with no step; result equals `din`.
- Reset (any time, including mid-SHIFT):
  - state IDLE, acc/cnt/op_r cleared, `dout`=0, `done`=0, `busy`=0.
  - An in-flight result is discarded.
- No arithmetic beyond cnt decrement; cnt never underflows because decrement is gated by cnt≠0.

## Timing
- Edge e0 samples `start`.
- `busy`=1 in cycles after e0 .. e(shamt+1)-1, i.e. shamt+1 cycles.
- `done`=1 for exactly the one cycle after edge e(shamt+1); `dout` updates on that same edge.
- Latency: start→done = shamt+1 edges (shamt=0 → 1; shamt=31 → 32).
- Back-to-back: `start` in the DONE cycle makes the next edge the new e0. `done` drops and `busy` rises; throughput is one op per shamt+2 cycles.
- Reset values: `busy`=0, `done`=0, `dout`=0.
- `done` and `busy` are never high together.

## Structure
- Shared package `shift_pkg`:
  - op encodings `SH_SLL`, `SH_SRL`, `SH_SRA`, `SH_ROR`.
  - state encodings `ST_IDLE`, `ST_SHIFT`, `ST_DONE`.
- Sub-module `shift1_unit`: purely combinational single-step shifter (inputs A[WIDTH], op[2]; output res[WIDTH]), implementing the step table above.
- `shift_seq` holds the FSM, acc/cnt/op_r registers and the `dout` register.

## Test plan
- Reset mid-op: start SLL shamt=20, assert `rst_n`=0 at cycle 5.
  - Immediately: `busy`=0, `done`=0, `dout`=0.
  - After release: IDLE; a fresh start works.
- SRL 0x8000_0000, shamt=4 → `done` after 5 edges, `dout`=0x0800_0000. `busy` high 5 cycles; `start` pulses during busy are ignored.
- SRA 0xF000_0000, shamt=31 → `dout`=0xFFFF_FFFF at edge 32.
- ROR 0x0000_0001, shamt=1 → `dout`=0x8000_0000.
- SLL 0x1234_5678, shamt=0 → `done` 1 edge after start, `dout`=0x1234_5678.
- Back-to-back: second start (SLL 0x1, shamt=31) held high during DONE of the first → second `done` 32 edges later, `dout`=0x8000_0000. First `dout` holds until then.
